// File: rtl/lab5_pkg.sv
// Shared definitions for the IRAM loader: word geometry, reset word and loader FSM states.
package lab5_pkg;

  localparam int unsigned IRAM_WORDS = 128;
  localparam int unsigned WORD_W     = 16;
  localparam int unsigned BYTE_W     = 8;

  // Value the write-data register idles at after reset.
  localparam logic [WORD_W-1:0] NOP = 16'h0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_HI,
    S_LO,
    S_WR,
    S_CSUM,
    S_FIN,
    S_FAIL
  } state_t;

endpackage

// File: rtl/iram_word_assembler.sv
// Byte-to-word capture for the IRAM loader, plus the running 8-bit session checksum.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_clear          start of a session: zero the captured bytes and the sum
//   i_acc_len        length byte accepted: sum restarts at the length value
//   i_acc_hi         hi byte accepted: capture it, add it to the sum
//   i_acc_lo         lo byte accepted: capture it, add it to the sum
//   i_byte           the byte being accepted
//   o_word_c         {hi, lo} including a lo byte accepted in this same cycle
//   o_sum            registered running sum (mod 256)
module iram_word_assembler
  import lab5_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_acc_len,
  input  logic              i_acc_hi,
  input  logic              i_acc_lo,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [WORD_W-1:0] o_word_c,
  output logic [BYTE_W-1:0] o_sum
);

  logic [BYTE_W-1:0] r_hi;
  logic [BYTE_W-1:0] r_lo;
  logic [BYTE_W-1:0] r_sum;

  // Byte capture and wrap-around checksum accumulation.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_sum <= '0;
    end else if (i_clear) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_sum <= '0;
    end else begin
      if (i_acc_len) begin
        r_sum <= i_byte;
      end
      if (i_acc_hi) begin
        r_hi  <= i_byte;
        r_sum <= r_sum + i_byte;
      end
      if (i_acc_lo) begin
        r_lo  <= i_byte;
        r_sum <= r_sum + i_byte;
      end
    end
  end

  // Bypass the lo byte so the loader can register the full word on the accepting edge.
  assign o_word_c = {r_hi, (i_acc_lo ? i_byte : r_lo)};
  assign o_sum    = r_sum;

endmodule

// File: rtl/iram_loader.sv
// Write side of the 16-bit instruction memory. Parses a byte stream
// (length, big-endian words, checksum), writes one IRAM word per received pair
// and stalls the processor while a session is open.
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_start             1-cycle pulse: open a load session (ignored while one is open)
//   i_rx_data/valid     incoming byte stream
//   o_rx_ready          byte accepted this cycle when i_rx_valid is also high
//   o_we                IRAM write strobe, one cycle per word
//   o_waddr             IRAM byte address {word_idx, 1'b0}
//   o_wdata             instruction word {hi, lo}
//   o_cpu_hold          high while a session is open
//   o_done / o_err      level result of the last session
module iram_loader
  import lab5_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MAX_WORDS = IRAM_WORDS
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [BYTE_W-1:0] i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [WORD_W-1:0] o_wdata,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_err
);

  localparam int unsigned IDX_W = ADDR_W - 1;
  localparam int unsigned CNT_W = BYTE_W;
  localparam int unsigned CMP_W = ((IDX_W > CNT_W) ? IDX_W : CNT_W) + 1;

  state_t              r_state;
  state_t              w_next;

  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_word_idx;
  logic                r_rx_ready;
  logic                r_we;
  logic [ADDR_W-1:0]   r_waddr;
  logic [WORD_W-1:0]   r_wdata;
  logic                r_cpu_hold;
  logic                r_done;
  logic                r_err;

  logic                w_accept;
  logic                w_len_bad;
  logic                w_last_word;
  logic [BYTE_W-1:0]   w_csum_c;
  logic                w_csum_ok;
  logic                w_clear;
  logic                w_acc_len;
  logic                w_acc_hi;
  logic                w_acc_lo;
  logic [WORD_W-1:0]   w_word_c;
  logic [BYTE_W-1:0]   w_sum;

  iram_word_assembler u_asm (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (w_clear),
    .i_acc_len (w_acc_len),
    .i_acc_hi  (w_acc_hi),
    .i_acc_lo  (w_acc_lo),
    .i_byte    (i_rx_data),
    .o_word_c  (w_word_c),
    .o_sum     (w_sum)
  );

  // Handshake and decode of the byte currently on the bus.
  assign w_accept    = i_rx_valid & r_rx_ready;
  assign w_len_bad   = (i_rx_data == '0) || (CMP_W'(i_rx_data) > CMP_W'(MAX_WORDS));
  // Compare in a wider width so a full-depth load (idx wraps to 0) still terminates.
  assign w_last_word = (CMP_W'(r_word_idx) + CMP_W'(1)) == CMP_W'(r_cnt);
  assign w_csum_c    = w_sum + i_rx_data;
  assign w_csum_ok   = (w_csum_c == '0);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and datapath strobes.
  always_comb begin
    w_next    = r_state;
    w_clear   = 1'b0;
    w_acc_len = 1'b0;
    w_acc_hi  = 1'b0;
    w_acc_lo  = 1'b0;
    case (r_state)
      S_IDLE, S_FIN, S_FAIL: begin
        if (i_start) begin
          w_next  = S_LEN;
          w_clear = 1'b1;
        end
      end
      S_LEN: begin
        if (w_accept) begin
          w_acc_len = 1'b1;
          w_next    = w_len_bad ? S_FAIL : S_HI;
        end
      end
      S_HI: begin
        if (w_accept) begin
          w_acc_hi = 1'b1;
          w_next   = S_LO;
        end
      end
      S_LO: begin
        if (w_accept) begin
          w_acc_lo = 1'b1;
          w_next   = S_WR;
        end
      end
      S_WR: begin
        w_next = w_last_word ? S_CSUM : S_HI;
      end
      S_CSUM: begin
        if (w_accept) begin
          w_next = w_csum_ok ? S_FIN : S_FAIL;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Registered outputs follow the state being entered, so they line up with it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_ready <= 1'b0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= NOP;
      r_cpu_hold <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_word_idx <= '0;
      r_cnt      <= '0;
    end else begin
      r_rx_ready <= (w_next inside {S_LEN, S_HI, S_LO, S_CSUM});
      r_we       <= (w_next == S_WR);
      r_cpu_hold <= (w_next inside {S_LEN, S_HI, S_LO, S_WR, S_CSUM});
      r_done     <= (w_next == S_FIN);
      r_err      <= (w_next == S_FAIL);

      // Address/data are loaded with the lo byte and then held until the next word.
      if (w_acc_lo) begin
        r_waddr <= {r_word_idx, 1'b0};
        r_wdata <= w_word_c;
      end

      if (w_clear) begin
        r_word_idx <= '0;
      end else if (r_state == S_WR) begin
        r_word_idx <= r_word_idx + IDX_W'(1);
      end

      if (w_acc_len) begin
        r_cnt <= i_rx_data;
      end
    end
  end

  assign o_rx_ready = r_rx_ready;
  assign o_we       = r_we;
  assign o_waddr    = r_waddr;
  assign o_wdata    = r_wdata;
  assign o_cpu_hold = r_cpu_hold;
  assign o_done     = r_done;
  assign o_err      = r_err;

endmodule

// File: tb/tb_iram_loader.sv
// Randomized self-checking bench for iram_loader against a stream-level reference model.
module tb_iram_loader;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        start    = 1'b0;
  logic [7:0]  rx_data  = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        we;
  logic [7:0]  waddr;
  logic [15:0] wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  stim[$];
  logic [7:0]  obs_addr[$];
  logic [15:0] obs_data[$];

  always #5 clk = ~clk;

  iram_loader dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .o_rx_ready (rx_ready),
    .o_we       (we),
    .o_waddr    (waddr),
    .o_wdata    (wdata),
    .o_cpu_hold (cpu_hold),
    .o_done     (done),
    .o_err      (err)
  );

  // Record every IRAM write as the memory would see it.
  always @(negedge clk) begin
    if (we) begin
      obs_addr.push_back(waddr);
      obs_data.push_back(wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one byte, optionally after idle cycles, and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int  idle;
    bit  ok;
    ok   = 1'b0;
    idle = (gap == 2) ? int'($urandom_range(3, 0)) : gap;
    repeat (idle) begin
      @(posedge clk);
      #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (rx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    if (!ok) chk("rx_ready_timeout", 32'(0), 32'(1));
  endtask

  // Length byte, 2*cnt random bytes, then a correct or deliberately wrong checksum.
  task automatic build_stream(input int cnt, input bit good);
    logic [7:0] s;
    logic [7:0] b;
    stim.delete();
    stim.push_back(8'(cnt));
    s = 8'(cnt);
    if (cnt == 0 || cnt > 128) return;
    for (int i = 0; i < 2 * cnt; i++) begin
      b = 8'($urandom);
      stim.push_back(b);
      s = s + b;
    end
    b = 8'h00 - s;
    if (!good) b = b + 8'($urandom_range(255, 1));
    stim.push_back(b);
  endtask

  // Drive stim as one session and check it against the stream-level model.
  task automatic run_session(input string name, input int gap, input bit mid_start);
    int  cnt;
    int  sum;
    int  nexp;
    bit  len_ok;
    bit  exp_done;
    logic [15:0] exp_word;

    cnt    = int'(stim[0]);
    len_ok = (cnt >= 1) && (cnt <= 128);
    sum    = 0;
    foreach (stim[i]) sum += int'(stim[i]);
    exp_done = len_ok && ((sum % 256) == 0);
    nexp     = len_ok ? cnt : 0;

    obs_addr.delete();
    obs_data.delete();

    // START with the length byte already offered: it must not be consumed that cycle.
    rx_data  = stim[0];
    rx_valid = 1'b1;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    rx_valid = 1'b0;
    chk({name, ".hold_open"}, 32'(cpu_hold), 32'(1));
    chk({name, ".done_cleared"}, 32'(done), 32'(0));
    chk({name, ".err_cleared"}, 32'(err), 32'(0));

    foreach (stim[i]) begin
      send_byte(stim[i], gap);
      if (i == 0 && len_ok) chk({name, ".hold_busy"}, 32'(cpu_hold), 32'(1));
      if (mid_start && i == 2) begin
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end

    // Result is visible in the cycle right after the last accepted byte.
    chk({name, ".done"}, 32'(done), 32'(exp_done));
    chk({name, ".err"}, 32'(err), 32'(!exp_done));
    chk({name, ".hold_released"}, 32'(cpu_hold), 32'(0));
    chk({name, ".we_count"}, 32'(obs_addr.size()), 32'(nexp));
    for (int i = 0; i < nexp && i < obs_addr.size(); i++) begin
      exp_word = {stim[1 + 2 * i], stim[2 + 2 * i]};
      chk({name, ".waddr"}, 32'(obs_addr[i]), 32'((2 * i) % 256));
      chk({name, ".wdata"}, 32'(obs_data[i]), 32'(exp_word));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, ".rx_ready"}, 32'(rx_ready), 32'(0));
    chk({name, ".we"}, 32'(we), 32'(0));
    chk({name, ".waddr"}, 32'(waddr), 32'(0));
    chk({name, ".wdata"}, 32'(wdata), 32'(0));
    chk({name, ".cpu_hold"}, 32'(cpu_hold), 32'(0));
    chk({name, ".done"}, 32'(done), 32'(0));
    chk({name, ".err"}, 32'(err), 32'(0));
  endtask

  initial begin
    #3;
    chk_reset_vals("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_hold", 32'(cpu_hold), 32'(0));

    // One word, good checksum.
    stim = '{8'h01, 8'hF0, 8'h01, 8'h0E};
    run_session("one_word", 0, 1'b0);

    // Three words with RX_VALID toggling.
    stim = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'h00};
    stim[7] = 8'h00 - (8'h03 + 8'h12 + 8'h34 + 8'h56 + 8'h78 + 8'h9A + 8'hBC);
    run_session("three_words", 1, 1'b0);

    // Bad checksum: the word is still written.
    stim = '{8'h01, 8'hF0, 8'h01, 8'h0F};
    run_session("bad_csum", 0, 1'b0);

    // Length errors.
    stim = '{8'h00};
    run_session("len_zero", 0, 1'b0);
    stim = '{8'h81};
    run_session("len_129", 2, 1'b0);

    // Full depth.
    build_stream(128, 1'b1);
    run_session("full_depth", 0, 1'b0);

    // START mid-session must be ignored.
    build_stream(4, 1'b1);
    run_session("mid_start", 2, 1'b1);

    // Reset after the hi byte of the first word.
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    send_byte(8'h02, 0);
    send_byte(8'hAB, 0);
    rst_n = 1'b0;
    #2;
    chk_reset_vals("mid_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    build_stream(2, 1'b1);
    run_session("after_reset", 0, 1'b0);

    // Random sessions.
    for (int k = 0; k < 10; k++) begin
      int c;
      c = int'($urandom_range(8, 1));
      if ($urandom_range(7, 0) == 0) c = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(255, 129));
      build_stream(c, $urandom_range(4, 0) != 0);
      run_session("random", int'($urandom_range(2, 0)), $urandom_range(1, 0) == 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
